muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_unit.sv | 139 +++++++++++++
 tb/tb_muldiv_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the iterative multiply/divide unit.
//   op_e    - operation code, RV32M funct3 encoding
//   state_e - control FSM states
package muldiv_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M-style multiply/divide, one operand bit per cycle.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in_valid/in_ready - request handshake (ready only when idle)
//   op, a, b          - funct3 operation, rs1 and rs2 operands
//   out_valid/out_ready - result handshake
//   out, zero         - result and result-is-zero flag (qualified by out_valid)
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            zero
);

  localparam int unsigned CntW  = $clog2(XLEN) + 1;
  localparam int unsigned ProdW = 2 * XLEN;
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN - 1){1'b0}}};

  state_e           state_q;
  op_e              op_q;
  logic [ProdW-1:0] acc_q;   // multiply: {hi, lo} product; divide: {remainder, quotient}
  logic [XLEN-1:0]  opd_q;   // multiplicand or divisor magnitude
  logic [CntW-1:0]  cnt_q;
  logic             neg_q;   // product / quotient sign
  logic             neg_r;   // remainder sign (dividend sign)
  logic [XLEN-1:0]  res_q;

  // Acceptance-time decode
  op_e             op_in;
  logic            a_sgn, b_sgn, neg_a, neg_b, div_zero, ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  assign op_in = op_e'(op);

  always_comb begin
    a_sgn    = op_in inside {OpMulh, OpMulhsu, OpDiv, OpRem};
    b_sgn    = op_in inside {OpMulh, OpDiv, OpRem};
    neg_a    = a_sgn & a[XLEN-1];
    neg_b    = b_sgn & b[XLEN-1];
    mag_a    = neg_a ? -a : a;
    mag_b    = neg_b ? -b : b;
    div_zero = op[2] && (b == '0);
    ovf      = (op_in == OpDiv || op_in == OpRem) && (a == MinNeg) && (b == '1);
    // op[1] separates REM/REMU from DIV/DIVU
    if (div_zero) special_res = op[1] ? a : '1;
    else          special_res = op[1] ? '0 : a;
  end

  // One iteration step, shared accumulator for both algorithms
  logic [XLEN:0]    mul_sum, div_part, div_trial;
  logic             div_ge;
  logic [ProdW-1:0] acc_nx, prod_fix;
  logic [XLEN-1:0]  quo_fix, rem_fix, final_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[ProdW-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    div_part  = {acc_q[ProdW-1:XLEN], acc_q[XLEN-1]};
    div_trial = div_part - {1'b0, opd_q};
    div_ge    = div_part >= {1'b0, opd_q};
    if (op_q[2]) begin
      // Restoring division: partial remainder always fits in XLEN bits
      acc_nx = {(div_ge ? div_trial[XLEN-1:0] : div_part[XLEN-1:0]),
                acc_q[XLEN-2:0], div_ge};
    end else begin
      acc_nx = {mul_sum, acc_q[XLEN-1:1]};
    end
    prod_fix = neg_q ? -acc_nx : acc_nx;
    quo_fix  = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    rem_fix  = neg_r ? -acc_nx[ProdW-1:XLEN] : acc_nx[ProdW-1:XLEN];
    unique case (op_q)
      OpMul:                     final_res = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: final_res = prod_fix[ProdW-1:XLEN];
      OpDiv, OpDivu:             final_res = quo_fix;
      default:                   final_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpMul;
      acc_q   <= '0;
      opd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      res_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q  <= op_in;
            neg_q <= neg_a ^ neg_b;
            neg_r <= neg_a;
            if (div_zero || ovf) begin
              res_q   <= special_res;
              state_q <= StDone;
            end else begin
              acc_q   <= op[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
              opd_q   <= op[2] ? mag_b : mag_a;
              cnt_q   <= CntW'(XLEN);
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          acc_q <= acc_nx;
          cnt_q <= cnt_q - 1'b1;
          // Sign correction folds into the last iteration
          if (cnt_q == CntW'(1)) begin
            res_q   <= final_res;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out       = res_q;
  assign zero      = out_valid && (res_q == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed, table-driven check of muldiv_unit (XLEN=32),
// plus hand-written sequences for result hold and mid-operation reset.
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, out_valid, out_ready, zero;
  logic [2:0]      op;
  logic [XLEN-1:0] a, b, out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Present a request at a negedge; returns after the acceptance edge
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Operands must be ignored once accepted
    op = 3'($urandom);
    a  = $urandom;
    b  = $urandom;
  endtask

  // Latency counted in cycles, the acceptance cycle being the first
  task automatic wait_done(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic consume(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({name, "_idle_valid"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int   lat;
    logic seen;
    logic [31:0] held;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33}; // MUL
    vecs[1]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33}; // MULHU
    vecs[2]  = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 33}; // MULH
    vecs[3]  = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};  // DIV ovf
    vecs[4]  = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 1};  // REM ovf
    vecs[5]  = '{3'd5, 32'd100,        32'd0,        32'hFFFFFFFF, 1};  // DIVU /0
    vecs[6]  = '{3'd7, 32'd100,        32'd0,        32'd100,      1};  // REMU /0
    vecs[7]  = '{3'd4, 32'hFFFFFFEC,   32'd6,        32'hFFFFFFFD, 33}; // DIV -20/6
    vecs[8]  = '{3'd6, 32'hFFFFFFEC,   32'd6,        32'hFFFFFFFE, 33}; // REM -20%6
    vecs[9]  = '{3'd2, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 33}; // MULHSU -1*2
    vecs[10] = '{3'd5, 32'd100,        32'd7,        32'd14,       33}; // DIVU
    vecs[11] = '{3'd7, 32'd100,        32'd7,        32'd2,        33}; // REMU
    vecs[12] = '{3'd6, 32'd20,         32'hFFFFFFFA, 32'd2,        33}; // REM 20%-6
    vecs[13] = '{3'd4, 32'd20,         32'hFFFFFFFA, 32'hFFFFFFFD, 33}; // DIV 20/-6
    vecs[14] = '{3'd4, 32'd7,          32'd0,        32'hFFFFFFFF, 1};  // DIV /0
    vecs[15] = '{3'd6, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9, 1};  // REM /0
    vecs[16] = '{3'd0, 32'h12345678,   32'h10,       32'h23456780, 33}; // MUL
    vecs[17] = '{3'd3, 32'h12345678,   32'h10,       32'h00000001, 33}; // MULHU

    // Reset with in_valid and out_ready held high: reset must win
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    op = 3'd0;
    a = 32'd3;
    b = 32'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out", {32'd0, out}, 64'd0);
    chk("rst_zero", {63'd0, zero}, 64'd0);

    for (int i = 0; i < 18; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_out", i), {32'd0, out}, {32'd0, vecs[i].exp});
      chk($sformatf("v%0d_zero", i), {63'd0, zero}, {63'd0, vecs[i].exp == 32'd0});
      chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, 64'd0);
      consume($sformatf("v%0d", i));
    end

    // Result must hold while the consumer stalls
    issue(3'd4, 32'hFFFFFFEC, 32'd6);
    wait_done(lat);
    held = 32'hFFFFFFFD;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d_out", k), {32'd0, out}, {32'd0, held});
      chk($sformatf("hold%0d_valid", k), {63'd0, out_valid}, 64'd1);
      chk($sformatf("hold%0d_in_ready", k), {63'd0, in_ready}, 64'd0);
      @(negedge clk);
    end
    consume("hold");

    // Reset in the middle of an operation
    issue(3'd0, 32'd5, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out", {32'd0, out}, 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", {63'd0, seen}, 64'd0);

    issue(3'd0, 32'd3, 32'd4);
    wait_done(lat);
    chk("after_rst_lat", 64'(lat), 64'd33);
    chk("after_rst_out", {32'd0, out}, 64'd12);
    consume("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
